alu_issue_ctrl: RTL

Command-issue stage that sits directly upstream of the 4-bit `_ALU` and feeds it. It accepts operand/opcode commands through a valid/ready handshake and buffers them in a small FIFO. It drives `A`/`B`/`Sel` to the ALU from stable registers, waits a programmable settle time, and captures the 8-bit `C` into a held result with its own valid/ready handshake. Illegal opcodes never reach the ALU and are flagged instead.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_issue_ctrl_if.sv | 39 +++
 rtl/_ALU.sv | 37 +++
 rtl/alu_cmd_fifo.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its issue stage.
//   OP_*         : opcode encodings, identical to the ones decoded by the ALU
//   state_e      : issue FSM state encoding
//   cmd_t        : one queued command {sel, a, b}
//   is_legal_op  : 1 when the opcode is one the ALU implements
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_GT  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1100;
   localparam logic [3:0] OP_SUB = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

   function automatic logic is_legal_op(input logic [3:0] sel);
      logic legal;
      case (sel)
         OP_ADD, OP_AND, OP_OR, OP_GT, OP_XOR,
         OP_MUL, OP_SHL, OP_EQ, OP_SHR, OP_SUB: legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus between a command producer / result consumer, the issue stage and the ALU.
//   In_*    : command stream (valid/ready), operands and opcode
//   A/B/Sel : registered drive to the ALU; C is the ALU's combinational result
//   Out_*   : held result stream (valid/ready), result, opcode and illegal flag
//   Count   : command FIFO occupancy
// Modport slave is the issue stage's view; master is the surrounding system's view.
interface alu_issue_ctrl_if #(
   parameter int unsigned DEPTH = 4
) ();

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          In_valid;
   logic          In_ready;
   logic [3:0]    In_A;
   logic [3:0]    In_B;
   logic [3:0]    In_Sel;
   logic [3:0]    A;
   logic [3:0]    B;
   logic [3:0]    Sel;
   logic [7:0]    C;
   logic          Out_valid;
   logic          Out_ready;
   logic [7:0]    Out_C;
   logic [3:0]    Out_Sel;
   logic          Out_Err;
   logic [CW-1:0] Count;

   modport slave (
      input  In_valid, In_A, In_B, In_Sel, C, Out_ready,
      output In_ready, A, B, Sel, Out_valid, Out_C, Out_Sel, Out_Err, Count
   );

   modport master (
      output In_valid, In_A, In_B, In_Sel, C, Out_ready,
      input  In_ready, A, B, Sel, Out_valid, Out_C, Out_Sel, Out_Err, Count
   );

endinterface

// File: rtl/_ALU.sv
// Combinational 4-bit ALU with an 8-bit result.
//   A, B : operands
//   Sel  : opcode (alu_pkg::OP_*); unimplemented opcodes return 0
//   C    : result
module _ALU
   import alu_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] Sel,
   output logic [7:0] C
);

   logic [7:0] a_ext;
   logic [7:0] b_ext;

   assign a_ext = {4'b0000, A};
   assign b_ext = {4'b0000, B};

   always_comb begin
      C = '0;
      case (Sel)
         OP_ADD:  C = a_ext + b_ext;
         OP_AND:  C = a_ext & b_ext;
         OP_OR:   C = a_ext | b_ext;
         OP_GT:   C = {7'b0, (A > B)};
         OP_XOR:  C = a_ext ^ b_ext;
         OP_MUL:  C = a_ext * b_ext;
         OP_SHL:  C = a_ext << B;
         OP_EQ:   C = {7'b0, (A == B)};
         OP_SHR:  C = a_ext >> B;
         OP_SUB:  C = a_ext - b_ext;
         default: C = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage, DEPTH x WIDTH, first-word fall-through.
//   CLK, RST_N : clock, asynchronous active-low reset
//   push/wdata : write when not full
//   pop/rdata  : rdata is the head entry; pop removes it when not empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module alu_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 12,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   // A full FIFO refuses the push even if the head leaves on the same edge.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 4-bit ALU. Queues commands, drives A/B/Sel from
// registers, waits SETTLE cycles, captures C and holds it until consumed.
// Illegal opcodes bypass the ALU and produce an error result directly.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave view of alu_issue_ctrl_if (command in, ALU drive, result out)
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input logic             CLK,
   input logic             RST_N,
   alu_issue_ctrl_if.slave bus
);

   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   cmd_t             wr_cmd;
   cmd_t             head;
   logic [CMD_W-1:0] head_raw;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             push;
   logic             pop;
   logic             head_legal;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       a_q;
   logic [3:0]       b_q;
   logic [3:0]       sel_q;
   logic             out_valid_q;
   logic [7:0]       out_c_q;
   logic [3:0]       out_sel_q;
   logic             out_err_q;

   assign wr_cmd = '{sel: bus.In_Sel, a: bus.In_A, b: bus.In_B};
   assign push   = bus.In_valid && !fifo_full;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (push),
      .wdata (wr_cmd),
      .pop   (pop),
      .rdata (head_raw),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head       = cmd_t'(head_raw);
   assign head_legal = is_legal_op(head.sel);

   // Pop from IDLE, or from HOLD on the edge the held result is consumed.
   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         IDLE:    pop = !fifo_empty;
         HOLD:    pop = bus.Out_ready && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_sel_q   <= '0;
         out_err_q   <= 1'b0;
      end else if (pop) begin
         if (head_legal) begin
            a_q         <= head.a;
            b_q         <= head.b;
            sel_q       <= head.sel;
            cnt_q       <= CNT_W'(SETTLE - 1);
            out_valid_q <= 1'b0;
            state_q     <= EXEC;
         end else begin
            // ALU drive is left untouched; the error result is held directly.
            out_c_q     <= '0;
            out_sel_q   <= head.sel;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            EXEC: begin
               if (cnt_q == '0) begin
                  out_c_q     <= bus.C;
                  out_sel_q   <= sel_q;
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            HOLD: begin
               if (bus.Out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.In_ready  = !fifo_full;
   assign bus.Count     = fifo_count;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.Sel       = sel_q;
   assign bus.Out_valid = out_valid_q;
   assign bus.Out_C     = out_c_q;
   assign bus.Out_Sel   = out_sel_q;
   assign bus.Out_Err   = out_err_q;

endmodule
